dmem_arbiter: RTL and testbench

- Shares the single-port data memory stage between two requesters: port 0 (core load/store unit) and port 1 (program loader / debug port).
- Uses valid/ready request handshakes and a one-cycle response pulse per port.
- Drives the memory stage's memRW, dataSec_i, dataW_i and addr_i inputs, and captures its registered data_o output.
- Guarantees memRW is high only during a single issue cycle, because the memory writes combinationally whenever memRW=1.

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory stage (port 0 = LSU, port 1 = loader/debug).
// Latency: accept at cycle A, memory access at A+1, one-cycle response pulse at A+3; one access per 4 cycles.
// Backpressure: reqX_ready pulses only in IDLE for the winner; requests seen while busy wait for IDLE.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter #(
  parameter int ADDR_MAX    = 20,
  parameter int INIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_sec,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_sec,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_rw,
  output logic [1:0]  mem_sec,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [31:0] ADDR_LIM  = 32'(ADDR_MAX);
  // INIT always lasts at least one cycle so the memory's own reset flag has cleared.
  localparam logic [15:0] INIT_LAST = (INIT_CYCLES > 0) ? 16'(INIT_CYCLES - 1) : 16'd0;

  state_t      state, state_nxt;
  logic [15:0] init_cnt;

  // Transaction latched at accept; the memory-facing fields live directly in mem_* registers.
  logic        lat_we;
  logic        lat_port;
  logic        lat_err;
  logic [31:0] cap_data;

  logic        grant_port;
  logic        accept;
  logic        sel_we;
  logic [1:0]  sel_sec;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        rsp_fire;

`ifdef ARB_ROUND_ROBIN_EN
  // Port holding priority when both request; flips to the other port on every accept.
  logic        rr_ptr;

  // Round-robin winner selection.
  always_comb begin
    grant_port = 1'b0;
    if (req0_valid && req1_valid) grant_port = rr_ptr;
    else                          grant_port = !req0_valid;
  end

  // Priority pointer update on each accept.
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= !grant_port;
  end
`else
  // Fixed priority: port 0 wins whenever it requests.
  always_comb begin
    grant_port = !req0_valid;
  end
`endif

  // Winner's request fields and the range check applied at accept.
  always_comb begin
    accept    = (state == IDLE) && (req0_valid || req1_valid) && !rst;
    sel_we    = grant_port ? req1_we    : req0_we;
    sel_sec   = grant_port ? req1_sec   : req0_sec;
    sel_addr  = grant_port ? req1_addr  : req0_addr;
    sel_wdata = grant_port ? req1_wdata : req0_wdata;
    // Only the base address is checked; the memory truncates bytes past the end itself.
    sel_err   = (sel_addr > ADDR_LIM) || (sel_sec == 2'b11);
  end

  // Next-state logic. Error transactions still walk ISSUE/CAPTURE (with no memory
  // access) so every response arrives exactly three cycles after its accept.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt >= INIT_LAST) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // State register; reset from any state aborts the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Counts cycles spent in INIT after reset release.
  always_ff @(posedge clk) begin
    if (rst || state != INIT) init_cnt <= 16'd0;
    else                      init_cnt <= init_cnt + 16'd1;
  end

  // Transaction control bits captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_port <= 1'b0;
      lat_err  <= 1'b0;
    end else if (accept) begin
      lat_we   <= sel_we;
      lat_port <= grant_port;
      lat_err  <= sel_err;
    end
  end

  // Memory address/size/data; loaded only for legal accesses, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= 32'h0;
      mem_sec   <= 2'b10;
      mem_wdata <= 32'h0;
    end else if (accept && !sel_err) begin
      mem_addr  <= sel_addr;
      mem_sec   <= sel_sec;
      mem_wdata <= sel_wdata;
    end
  end

  // Response data formed in CAPTURE, when the memory's registered output is valid.
  always_ff @(posedge clk) begin
    if (rst)                    cap_data <= 32'h0;
    else if (state == CAPTURE) begin
      if (lat_err)     cap_data <= 32'hFFFF_FFFF;
      else if (lat_we) cap_data <= 32'h0;
      else             cap_data <= mem_rdata;
    end
  end

  // Handshake, response and write-strobe outputs; all forced low while rst is high.
  always_comb begin
    rsp_fire   = (state == RESP) && !rst;
    req0_ready = accept && !grant_port;
    req1_ready = accept && grant_port;
    rsp0_valid = rsp_fire && !lat_port;
    rsp1_valid = rsp_fire && lat_port;
    rsp0_rdata = rsp0_valid ? cap_data : 32'h0;
    rsp1_rdata = rsp1_valid ? cap_data : 32'h0;
    rsp0_err   = rsp0_valid && lat_err;
    rsp1_err   = rsp1_valid && lat_err;
    // The memory writes combinationally, so the strobe must be confined to ISSUE.
    mem_rw     = (state == ISSUE) && lat_we && !lat_err && !rst;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: big-endian memory stage model plus a cycle-level reference model.
// The reference predicts accepts, strobes and responses from timing rules (accept, +1 access, +3 response).
// Directed requests add hand-computed literal checks on data, latency and grant order.
module tb_dmem_arbiter;
  localparam int ADDR_MAX    = 20;
  localparam int INIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [1:0]  req0_sec;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [1:0]  req1_sec;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_rw;
  logic [1:0]  mem_sec;
  logic [31:0] mem_wdata, mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  dmem_arbiter #(.ADDR_MAX(ADDR_MAX), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_sec(req0_sec), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_sec(req1_sec), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_rw(mem_rw), .mem_sec(mem_sec), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Two byte arrays: env_mem is the memory stage, ref_mem is the model's own view.
  logic [7:0] env_mem [0:ADDR_MAX];
  logic [7:0] ref_mem [0:ADDR_MAX];

  function automatic logic [7:0] mb(input bit r, input logic [31:0] i);
    if (i > 32'(ADDR_MAX)) return 8'h0;
    return r ? ref_mem[i[4:0]] : env_mem[i[4:0]];
  endfunction

  function automatic logic [31:0] mread(input bit r, input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'b00:   return {24'h0, mb(r, a)};
      2'b01:   return {16'h0, mb(r, a), mb(r, a + 1)};
      default: return {mb(r, a), mb(r, a + 1), mb(r, a + 2), mb(r, a + 3)};
    endcase
  endfunction

  task automatic mwrite(input bit r, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [7:0] b [4];
    int n;
    b[0] = d[31:24]; b[1] = d[23:16]; b[2] = d[15:8]; b[3] = d[7:0];
    n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ia;
      ia = a + 32'(k);
      if (ia <= 32'(ADDR_MAX)) begin
        if (r) ref_mem[ia[4:0]] = b[4 - n + k];
        else   env_mem[ia[4:0]] = b[4 - n + k];
      end
    end
  endtask

  initial for (int i = 0; i <= ADDR_MAX; i++) begin env_mem[i] = 8'h0; ref_mem[i] = 8'h0; end

  // Memory stage: combinational write while memRW is high, registered read.
  always @(posedge clk) begin
    if (mem_rw) mwrite(1'b0, mem_addr, mem_sec, mem_wdata);
    mem_rdata <= mread(1'b0, mem_addr, mem_sec);
  end

  // Reference model and per-cycle compare.
  int          next_ok = 0;
  bit          rst_prev = 0;
  bit          iss_pend = 0, rsp_pend = 0;
  int          iss_cyc, rsp_cyc;
  logic        iss_we, rsp_port, rsp_err_e, ptr = 1'b0;
  logic [1:0]  iss_sec;
  logic [31:0] iss_addr, iss_wdata, rsp_data;
  int          rw_cnt = 0, rsp0_cnt = 0;
  int          gq[$];

  initial forever begin
    @(negedge clk);
    if (req0_ready) gq.push_back(0);
    if (req1_ready) gq.push_back(1);
    if (mem_rw) rw_cnt++;
    if (rsp0_valid) rsp0_cnt++;
    if (rst) begin
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
      chk("rst_rsp_err", 32'({rsp1_err, rsp0_err}), 0);
      chk("rst_rdata0", rsp0_rdata, 0);
      chk("rst_rdata1", rsp1_rdata, 0);
      chk("rst_mem_rw", 32'(mem_rw), 0);
      if (rst_prev) begin
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_sec", 32'(mem_sec), 2);
        chk("rst_mem_wdata", mem_wdata, 0);
      end
      next_ok  = cyc + 1 + INIT_CYCLES;
      iss_pend = 0;
      rsp_pend = 0;
      ptr      = 1'b0;
    end else begin
      logic e_r0, e_r1, e_rw, e_v0, e_v1;
      e_r0 = 0; e_r1 = 0;
      if (cyc >= next_ok && (req0_valid || req1_valid)) begin
        logic        w, we, er;
        logic [1:0]  s;
        logic [31:0] a, d;
`ifdef ARB_ROUND_ROBIN_EN
        w = (req0_valid && req1_valid) ? ptr : !req0_valid;
`else
        w = !req0_valid;
`endif
        ptr = !w;
        e_r0 = !w; e_r1 = w;
        we = w ? req1_we : req0_we;
        s  = w ? req1_sec : req0_sec;
        a  = w ? req1_addr : req0_addr;
        d  = w ? req1_wdata : req0_wdata;
        er = (a > 32'(ADDR_MAX)) || (s == 2'b11);
        rsp_pend = 1; rsp_cyc = cyc + 3; rsp_port = w; rsp_err_e = er;
        if (er)      rsp_data = 32'hFFFF_FFFF;
        else if (we) rsp_data = 32'h0;
        else         rsp_data = mread(1'b1, a, s);
        if (!er) begin
          iss_pend = 1; iss_cyc = cyc + 1; iss_we = we;
          iss_sec = s; iss_addr = a; iss_wdata = d;
          if (we) mwrite(1'b1, a, s, d);
        end
        next_ok = cyc + 4;
      end
      chk("ready0", 32'(req0_ready), 32'(e_r0));
      chk("ready1", 32'(req1_ready), 32'(e_r1));
      e_rw = iss_pend && iss_cyc == cyc && iss_we;
      chk("mem_rw", 32'(mem_rw), 32'(e_rw));
      if (iss_pend && iss_cyc == cyc) begin
        chk("mem_addr", mem_addr, iss_addr);
        chk("mem_sec", 32'(mem_sec), 32'(iss_sec));
        if (iss_we) chk("mem_wdata", mem_wdata, iss_wdata);
        iss_pend = 0;
      end
      e_v0 = rsp_pend && rsp_cyc == cyc && !rsp_port;
      e_v1 = rsp_pend && rsp_cyc == cyc && rsp_port;
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
      if (e_v0) begin
        chk("rsp0_rdata", rsp0_rdata, rsp_data);
        chk("rsp0_err", 32'(rsp0_err), 32'(rsp_err_e));
      end
      if (e_v1) begin
        chk("rsp1_rdata", rsp1_rdata, rsp_data);
        chk("rsp1_err", 32'(rsp1_err), 32'(rsp_err_e));
      end
      if (rsp_pend && rsp_cyc == cyc) rsp_pend = 0;
    end
    rst_prev = rst;
  end

  // One request on port p; returns response fields, latency and accept cycle.
  task automatic do_req(input int p, input logic we, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int acc);
    rd = 32'h0; er = 1'b0; lat = -1; acc = -1;
    if (p == 0) begin req0_we = we; req0_sec = s; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
    else        begin req1_we = we; req1_sec = s; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc < 0) begin
      chk("accept_timeout", 1, 0);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((p == 0) ? rsp0_valid : rsp1_valid) begin
        rd  = (p == 0) ? rsp0_rdata : rsp1_rdata;
        er  = (p == 0) ? rsp0_err : rsp1_err;
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("rsp_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, rel, snap, snap2, t;
    int          exp_g [4];
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_sec = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_sec = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;

    // Word write right after reset release: held off for INIT_CYCLES.
    snap = rw_cnt;
    do_req(0, 1'b1, 2'b10, 32'd4, 32'hDEADBEEF, rd, er, lat, acc);
    chk("lit_init_hold", 32'(acc - rel), 32'(INIT_CYCLES));
    chk("lit_wr_latency", 32'(lat), 3);
    chk("lit_wr_err", 32'(er), 0);
    chk("lit_wr_rdata", rd, 32'h0);
    chk("lit_wr_rw_cycles", 32'(rw_cnt - snap), 1);

    do_req(0, 1'b0, 2'b10, 32'd4, 32'h0, rd, er, lat, acc);
    chk("lit_rd_word", rd, 32'hDEADBEEF);
    chk("lit_rd_latency", 32'(lat), 3);
    do_req(0, 1'b0, 2'b00, 32'd5, 32'h0, rd, er, lat, acc);
    chk("lit_rd_byte5", rd, 32'h000000AD);
    do_req(0, 1'b0, 2'b01, 32'd6, 32'h0, rd, er, lat, acc);
    chk("lit_rd_half6", rd, 32'h0000BEEF);

    // Out-of-range address and illegal size on port 1: no memory strobe.
    snap = rw_cnt;
    do_req(1, 1'b0, 2'b10, 32'd21, 32'h0, rd, er, lat, acc);
    chk("lit_err_rdata", rd, 32'hFFFFFFFF);
    chk("lit_err_flag", 32'(er), 1);
    chk("lit_err_latency", 32'(lat), 3);
    do_req(1, 1'b1, 2'b11, 32'd0, 32'h12345678, rd, er, lat, acc);
    chk("lit_sec11_err", 32'(er), 1);
    chk("lit_err_no_rw", 32'(rw_cnt - snap), 0);

    // Word write crossing the end is truncated, not an error.
    do_req(1, 1'b1, 2'b10, 32'd19, 32'h11223344, rd, er, lat, acc);
    chk("lit_trunc_err", 32'(er), 0);
    do_req(1, 1'b0, 2'b10, 32'd18, 32'h0, rd, er, lat, acc);
    chk("lit_trunc_rd", rd, 32'h00112200);

    // Reset during CAPTURE of a port 0 read drops the response.
    snap = rsp0_cnt; snap2 = rw_cnt;
    req0_we = 1'b0; req0_sec = 2'b10; req0_addr = 32'd4; req0_valid = 1'b1;
    t = 0;
    while (t < 20 && !(t > 0 && req0_ready)) begin @(negedge clk); t++; end
    if (!req0_ready) chk("mid_accept_timeout", 1, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("lit_mid_no_rsp", 32'(rsp0_cnt - snap), 0);
    chk("lit_mid_no_rw", 32'(rw_cnt - snap2), 0);
    do_req(0, 1'b0, 2'b10, 32'd4, 32'h0, rd, er, lat, acc);
    chk("lit_post_rst_rd", rd, 32'hDEADBEEF);
    chk("lit_post_rst_lat", 32'(lat), 3);

    // Both ports requesting continuously from a fresh reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gq.delete();
    req0_we = 1'b0; req0_sec = 2'b10; req0_addr = 32'd4; req0_valid = 1'b1;
    req1_we = 1'b0; req1_sec = 2'b10; req1_addr = 32'd8; req1_valid = 1'b1;
    t = 0;
    while (t < 40 && gq.size() < 4) begin @(negedge clk); t++; end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    chk("lit_grant_count", 32'(gq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) chk($sformatf("lit_grant%0d", i), 32'(gq[i]), 32'(exp_g[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
